// File: rtl/yuv_pkg.sv
// Shared definitions for the YUV 4:2:2 byte packer.
//   phase_e            : index of the next expected byte in a U,Y0,V,Y1 group
//   DEFAULT_FIFO_DEPTH : default number of 32-bit words in the output FIFO
//   *_LSB              : bit position of each byte lane inside a packed word
//   pack_word()        : assembles the four lanes into one 32-bit word
package yuv_pkg;

  typedef enum logic [1:0] {
    PH_U  = 2'd0,
    PH_Y0 = 2'd1,
    PH_V  = 2'd2,
    PH_Y1 = 2'd3
  } phase_e;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  localparam int U_LSB  = 24;
  localparam int Y0_LSB = 16;
  localparam int V_LSB  = 8;
  localparam int Y1_LSB = 0;

  function automatic logic [31:0] pack_word(input logic [7:0] u,
                                            input logic [7:0] y0,
                                            input logic [7:0] v,
                                            input logic [7:0] y1);
    logic [31:0] w;
    w = '0;
    w[U_LSB  +: 8] = u;
    w[Y0_LSB +: 8] = y0;
    w[V_LSB  +: 8] = v;
    w[Y1_LSB +: 8] = y1;
    return w;
  endfunction

endpackage

// File: rtl/yuv_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk     : clock, all state on rising edge
//   reset   : synchronous active-low reset (pointers and count only)
//   clear   : synchronous flush; pushes and pops in the same cycle are ignored
//   push    : write request for wr_data
//   wr_data : word to write
//   pop     : remove the head word (ignored when empty)
//   rd_data : head word, 0 while empty
//   count   : occupied entries
//   push_ok : the push of this cycle is accepted
//   empty   : no entries
module yuv_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             push_ok,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop frees a slot for a push in the same cycle even when full.
  // No pass-through when empty: the pushed word becomes visible next cycle.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);
  assign push_ok = do_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are AW bits wide, so increment wraps modulo DEPTH.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; empty masks stale contents on the read side.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/yuv422_packer.sv
// Packs a U,Y0,V,Y1 byte stream into 32-bit words and queues them.
//   clk        : clock
//   reset      : synchronous active-low reset
//   in_valid   : yuv_in carries a byte this cycle
//   yuv_in     : byte stream, order U, Y0, V, Y1
//   clear      : synchronous flush of phase, FIFO and overflow
//   out_ready  : downstream takes the head word
//   out_valid  : head word present on out_data
//   out_data   : {U, Y0, V, Y1}
//   fifo_count : occupied FIFO entries
//   phase      : index of next expected byte
//   overflow   : sticky, a completed word was dropped
//   word_cnt   : completed words written to the FIFO (wraps)
module yuv422_packer
  import yuv_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    yuv_in,
  input  logic                          clear,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [31:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    phase,
  output logic                          overflow,
  output logic [15:0]                   word_cnt
);

  phase_e      phase_q, phase_d;
  logic [7:0]  held_q [3];
  logic [7:0]  held_d [3];
  logic        overflow_q, overflow_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        accept;
  logic        word_done;
  logic        push_ok;
  logic        fifo_empty;
  logic [31:0] word;

  // A byte arriving in a clear cycle is discarded.
  assign accept    = in_valid && !clear;
  assign word_done = accept && (phase_q == PH_Y1);
  // Y1 is never held; the word is built from the live byte.
  assign word      = pack_word(held_q[0], held_q[1], held_q[2], yuv_in);

  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    assign held_d[gi] = (accept && (phase_q == phase_e'(gi))) ? yuv_in : held_q[gi];
  end

  always_comb begin
    phase_d    = phase_q;
    overflow_d = overflow_q;
    word_cnt_d = word_cnt_q;
    if (clear) begin
      phase_d    = PH_U;
      overflow_d = 1'b0;
    end else begin
      if (accept) phase_d = phase_e'(phase_q + 2'd1);
      if (word_done && !push_ok) overflow_d = 1'b1;
      if (push_ok) word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q    <= PH_U;
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
      for (int i = 0; i < 3; i++) held_q[i] <= '0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      word_cnt_q <= word_cnt_d;
      for (int i = 0; i < 3; i++) held_q[i] <= held_d[i];
    end
  end

  yuv_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (word_done),
    .wr_data (word),
    .pop     (out_ready),
    .rd_data (out_data),
    .count   (fifo_count),
    .push_ok (push_ok),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign phase     = phase_q;
  assign overflow  = overflow_q;
  assign word_cnt  = word_cnt_q;

endmodule
